// File: rtl/arb_mux_pkg.sv
// Shared definitions for the round-robin registered selector: index-width helper,
// reset constants, output-register state encoding and CPU memory-port channel numbers.
package arb_mux_pkg;

  // max(1, ceil(log2 n)) so a single channel still gets a 1-bit index
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

  localparam logic OUT_DATA_RST_BIT = 1'b0;
  localparam int   OUT_SEL_RST      = 0;

  localparam int CH_FETCH = 0;
  localparam int CH_DATA  = 1;
  localparam int CH_DEBUG = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/arb_mux_if.sv
// Request-side and output-side handshake bundle of arb_mux.
// master = requesters plus consumer, slave = the selector itself.
interface arb_mux_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
);
  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_data;
  logic [N-1:0]       req_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/arb_mux_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from ptr, modulo N.
// Reusable by other arbiters; grant is one-hot or zero.
module rr_pick
  import arb_mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx
);

  logic [SEL_W:0] sum_s;
  logic [SEL_W:0] pos_s;

  // Scan from the farthest offset back to ptr so the nearest request is written last
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    sum_s     = '0;
    pos_s     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum_s = {1'b0, ptr} + (SEL_W + 1)'(k);
      pos_s = (sum_s >= (SEL_W + 1)'(N)) ? (sum_s - (SEL_W + 1)'(N)) : sum_s;
      if (req[pos_s[SEL_W-1:0]]) begin
        grant                      = '0;
        grant[pos_s[SEL_W-1:0]]    = 1'b1;
        grant_idx                  = pos_s[SEL_W-1:0];
      end else begin
        grant     = grant;
        grant_idx = grant_idx;
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel round-robin arbiter feeding one registered output slot with valid/ready
// on both sides; each accepted word is delivered once, tagged with its source channel.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N)
) (
  input logic        clk,
  input logic        resetn,
  arb_mux_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic [N-1:0]     grant_s;
  logic [SEL_W-1:0] grant_idx_s;
  logic             load_s;
  logic             accept_s;
  logic [WIDTH-1:0] win_data_s;

  rr_pick #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_pick (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  // Slot can take a word when empty or being drained; reset masks every grant
  always_comb begin
    load_s        = (state_q == ST_EMPTY) || bus.out_ready;
    accept_s      = resetn && load_s && (|bus.req_valid);
    bus.req_ready = accept_s ? grant_s : '0;
  end

  // AND-OR data select from the one-hot grant
  always_comb begin
    win_data_s = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_s[i]) begin
        win_data_s = win_data_s | bus.req_data[i*WIDTH +: WIDTH];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  // Next-state: refill on accept (drain and refill may coincide), else drain or hold
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    if (accept_s) begin
      state_d = ST_FULL;
      data_d  = win_data_s;
      sel_d   = grant_idx_s;
      ptr_d   = (grant_idx_s == SEL_W'(N - 1)) ? '0 : (grant_idx_s + SEL_W'(1));
    end else if ((state_q == ST_FULL) && bus.out_ready) begin
      state_d = ST_EMPTY;
    end else begin
      state_d = state_q;
    end
  end

  // Output slot and priority pointer; reset discards any held word
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
      data_q  <= {WIDTH{OUT_DATA_RST_BIT}};
      sel_q   <= SEL_W'(OUT_SEL_RST);
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux (N=4): directed vector table for the listed scenarios, then
// randomized traffic compared against a round-robin reference model.
module tb_arb_mux;

  localparam int WIDTH = 32;
  localparam int N     = 4;
  localparam int SEL_W = 2;

  logic clk;
  logic resetn;

  arb_mux_if #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) bus ();

  arb_mux #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          m_valid;
  int          m_sel;
  int          m_ptr;
  logic [31:0] m_data;

  typedef struct {
    logic         rst;
    logic [3:0]   rv;
    logic [127:0] rd;
    logic         ordy;
    logic [3:0]   e_rdy;
    logic         e_v;
    logic [1:0]   e_sel;
    logic [31:0]  e_data;
  } vec_t;

  vec_t vt[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pk(input logic [31:0] d0, input logic [31:0] d1,
                                      input logic [31:0] d2, input logic [31:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [3:0] rv, input logic [127:0] rd,
                              input logic ordy, input logic [3:0] e_rdy, input logic e_v,
                              input logic [1:0] e_sel, input logic [31:0] e_data);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rd = rd; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_v = e_v; v.e_sel = e_sel; v.e_data = e_data;
    return v;
  endfunction

  // Model: first requesting channel at or after ptr, wrapping; -1 when none
  function automatic int m_winner(input logic [3:0] rv);
    for (int k = 0; k < N; k++) begin
      if (rv[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [3:0] m_ready(input logic rst, input logic [3:0] rv, input logic ordy);
    int w;
    w = m_winner(rv);
    if (rst && (m_valid == 0 || ordy) && w >= 0) return 4'(1 << w);
    return 4'b0000;
  endfunction

  task automatic m_step(input logic rst, input logic [3:0] rv, input logic [127:0] rd,
                        input logic ordy);
    int w;
    w = m_winner(rv);
    if (!rst) begin
      m_valid = 0; m_sel = 0; m_ptr = 0; m_data = 32'h0;
    end else if ((m_valid == 0 || ordy) && w >= 0) begin
      m_data  = rd[w*32 +: 32];
      m_sel   = w;
      m_valid = 1;
      m_ptr   = (w + 1) % N;
    end else if (m_valid != 0 && ordy) begin
      m_valid = 0;
    end
  endtask

  // One clock: drive at negedge, sample ready before the edge, outputs just after
  task automatic cycle(input logic rst, input logic [3:0] rv, input logic [127:0] rd,
                       input logic ordy, output logic [3:0] rdy_o, output logic [3:0] mrdy_o,
                       output logic v_o, output logic [1:0] s_o, output logic [31:0] d_o);
    @(negedge clk);
    resetn        = rst;
    bus.req_valid = rv;
    bus.req_data  = rd;
    bus.out_ready = ordy;
    #1;
    rdy_o  = bus.req_ready;
    mrdy_o = m_ready(rst, rv, ordy);
    @(posedge clk);
    m_step(rst, rv, rd, ordy);
    #1;
    v_o = bus.out_valid;
    s_o = bus.out_sel;
    d_o = bus.out_data;
  endtask

  initial begin
    logic [127:0] rot;
    logic [127:0] bp;
    logic [127:0] rr;
    logic [3:0]   rdy;
    logic [3:0]   mrdy;
    logic         v;
    logic [1:0]   s;
    logic [31:0]  d;
    logic [3:0]   rv;
    logic [127:0] rd;
    logic         ordy;
    logic         rst;

    resetn = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_data  = 128'h0;
    bus.out_ready = 1'b0;
    m_valid = 0; m_sel = 0; m_ptr = 0; m_data = 32'h0;

    rot = pk(32'h10, 32'h11, 32'h12, 32'h13);
    bp  = pk(32'h0, 32'hA1, 32'h0, 32'hA3);
    rr  = pk(32'h0, 32'h61, 32'h62, 32'h0);

    // reset with every channel requesting
    for (int i = 0; i < 3; i++) vt[i] = mk(1'b0, 4'b1111, rot, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0);
    // rotation 0..3,0..3 starting at channel 0 after release
    for (int i = 0; i < 8; i++)
      vt[3+i] = mk(1'b1, 4'b1111, rot, 1'b1, 4'(1 << (i % 4)), 1'b1, 2'(i % 4), 32'(32'h10 + (i % 4)));
    // single channel 2
    vt[11] = mk(1'b1, 4'b0100, pk(32'h0, 32'h0, 32'hDEADBEEF, 32'h0), 1'b1, 4'b0100, 1'b1, 2'd2, 32'hDEADBEEF);
    // backpressure: held word stable, no grants
    for (int i = 0; i < 5; i++) vt[12+i] = mk(1'b1, 4'b1010, bp, 1'b0, 4'b0000, 1'b1, 2'd2, 32'hDEADBEEF);
    // release: refill in same cycle goes to channel 3 (after held sel 2)
    vt[17] = mk(1'b1, 4'b1010, bp, 1'b1, 4'b1000, 1'b1, 2'd3, 32'hA3);
    // drain to empty from sel 1, then lone channel 3
    vt[18] = mk(1'b1, 4'b0010, pk(32'h0, 32'hB1, 32'h0, 32'h0), 1'b1, 4'b0010, 1'b1, 2'd1, 32'hB1);
    vt[19] = mk(1'b1, 4'b0000, 128'h0, 1'b1, 4'b0000, 1'b0, 2'd1, 32'hB1);
    vt[20] = mk(1'b1, 4'b1000, pk(32'h0, 32'h0, 32'h0, 32'hC3), 1'b0, 4'b1000, 1'b1, 2'd3, 32'hC3);
    // reset mid-transfer: hold CAFE0000 (ptr now 2), reset, grant restarts from channel 0
    vt[21] = mk(1'b1, 4'b0010, pk(32'h0, 32'hCAFE0000, 32'h0, 32'h0), 1'b1, 4'b0010, 1'b1, 2'd1, 32'hCAFE0000);
    vt[22] = mk(1'b1, 4'b0000, 128'h0, 1'b0, 4'b0000, 1'b1, 2'd1, 32'hCAFE0000);
    vt[23] = mk(1'b0, 4'b0110, rr, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0);
    vt[24] = mk(1'b1, 4'b0110, rr, 1'b0, 4'b0010, 1'b1, 2'd1, 32'h61);

    for (int i = 0; i < 25; i++) begin
      cycle(vt[i].rst, vt[i].rv, vt[i].rd, vt[i].ordy, rdy, mrdy, v, s, d);
      chk($sformatf("vec%0d req_ready", i), 32'(rdy), 32'(vt[i].e_rdy));
      chk($sformatf("vec%0d out_valid", i), 32'(v), 32'(vt[i].e_v));
      chk($sformatf("vec%0d out_sel", i), 32'(s), 32'(vt[i].e_sel));
      chk($sformatf("vec%0d out_data", i), d, vt[i].e_data);
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      rst  = ($urandom_range(0, 39) != 0);
      rv   = 4'($urandom_range(0, 15));
      rd   = {$urandom, $urandom, $urandom, $urandom};
      ordy = ($urandom_range(0, 3) != 0);
      cycle(rst, rv, rd, ordy, rdy, mrdy, v, s, d);
      chk($sformatf("rnd%0d req_ready", c), 32'(rdy), 32'(mrdy));
      chk($sformatf("rnd%0d out_valid", c), 32'(v), 32'(m_valid));
      if (m_valid != 0) begin
        chk($sformatf("rnd%0d out_sel", c), 32'(s), 32'(m_sel));
        chk($sformatf("rnd%0d out_data", c), d, m_data);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
